// File: rtl/rng_pkg.sv
// Shared FSM encodings, mode constants and the width type for rng_param_gen.
package rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_PRESENT = 2'd2
    } fsm_e;

    localparam logic MODE_CNT  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    localparam int unsigned FSM_W = 2;

endpackage : rng_pkg

// File: rtl/rng_next_val.sv
// Combinational next-state function: counter with wrap, or Galois LFSR step with zero-lock recovery.
module rng_next_val
    import rng_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter int unsigned     MAX_VAL   = 9,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(4'b1100),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1)
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             mode,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    // Counter wraps to zero at or above the bound; LFSR escapes the all-zero lock via SEED.
    always_comb begin
        nxt = '0;
        if (mode == MODE_LFSR) begin
            if (cur == '0) begin
                nxt = SEED;
            end else begin
                nxt = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
            end
        end else begin
            nxt = (cur >= MAX_V) ? '0 : cur + WIDTH'(1);
        end
    end

endmodule : rng_next_val

// File: rtl/rng_param_gen.sv
// Button-driven random number generator: advances while the button is held, presents the value on release.
module rng_param_gen
    import rng_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      MAX_VAL   = 9,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(4'b1100),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(0)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             buttonPush,
    input  logic             mode,
    input  logic             seedLoad,
    input  logic [WIDTH-1:0] seedVal,
    input  logic             rngAck,
    output logic [WIDTH-1:0] rngOut,
    output logic             rngValid,
    output logic             busy,
    output logic             overrun
);

    fsm_e             fsm_q;
    fsm_e             fsm_d;
    logic             mode_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] seed_eff;
    logic             capture_c;
    logic             ack_take_c;
    logic             ovr_set_c;

    rng_next_val #(
        .WIDTH     (WIDTH),
        .MAX_VAL   (MAX_VAL),
        .LFSR_TAPS (LFSR_TAPS),
        .SEED      (SEED)
    ) u_next (
        .cur  (state_q),
        .mode (mode_q),
        .nxt  (next_val)
    );

    // A zero seed would lock the LFSR, so substitute the recovery value in LFSR mode.
    assign seed_eff = ((mode_q == MODE_LFSR) && (seedVal == '0)) ? SEED : seedVal;

    // Busy is a pure decode of the registered FSM state.
    assign busy = (fsm_q == ST_HOLD);

    // State register: seed load beats advance, advance runs in every FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_VAL;
        end else if (seedLoad) begin
            state_q <= seed_eff;
        end else if (!buttonPush) begin
            state_q <= next_val;
        end
    end

    // FSM and mode registers; mode is only sampled while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            mode_q <= MODE_CNT;
        end else begin
            fsm_q <= fsm_d;
            if (fsm_q == ST_IDLE) begin
                mode_q <= mode;
            end
        end
    end

    // Next-state and per-cycle action strobes.
    always_comb begin
        fsm_d      = fsm_q;
        capture_c  = 1'b0;
        ack_take_c = 1'b0;
        ovr_set_c  = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                if (!buttonPush) begin
                    fsm_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (buttonPush) begin
                    fsm_d     = ST_PRESENT;
                    capture_c = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (!buttonPush) begin
                    ovr_set_c = 1'b1;
                end
                if (rngAck) begin
                    ack_take_c = 1'b1;
                    fsm_d      = buttonPush ? ST_IDLE : ST_HOLD;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // Output registers: capture on release, clear valid on ack, sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rngOut   <= '0;
            rngValid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (capture_c) begin
                rngOut   <= state_q;
                rngValid <= 1'b1;
            end else if (ack_take_c) begin
                rngValid <= 1'b0;
            end
            if (ovr_set_c) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule : rng_param_gen

// File: tb/tb_rng_param_gen.sv
// Directed bench for rng_param_gen with hand-computed expectations (WIDTH=4, MAX_VAL=9, taps 1100, SEED=1).
module tb_rng_param_gen;

    logic       clk;
    logic       rst;
    logic       buttonPush;
    logic       mode;
    logic       seedLoad;
    logic [3:0] seedVal;
    logic       rngAck;
    logic [3:0] rngOut;
    logic       rngValid;
    logic       busy;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    rng_param_gen #(
        .WIDTH     (4),
        .MAX_VAL   (9),
        .LFSR_TAPS (4'b1100),
        .SEED      (4'd1),
        .RESET_VAL (4'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buttonPush (buttonPush),
        .mode       (mode),
        .seedLoad   (seedLoad),
        .seedVal    (seedVal),
        .rngAck     (rngAck),
        .rngOut     (rngOut),
        .rngValid   (rngValid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one posedge and settle before sampling or changing inputs.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        buttonPush = 1'b1;
        mode       = 1'b0;
        seedLoad   = 1'b0;
        seedVal    = 4'd0;
        rngAck     = 1'b0;
        tick(2);
        rst = 1'b0;

        // Reset state
        chk("rst_out",     32'(rngOut),      32'd0);
        chk("rst_valid",   32'(rngValid),    32'd0);
        chk("rst_overrun", 32'(overrun),     32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_state",   32'(dut.state_q), 32'd0);

        // Counter: four advances then release
        buttonPush = 1'b0;
        tick();
        chk("cnt_busy", 32'(busy), 32'd1);
        tick(3);
        chk("cnt_state4", 32'(dut.state_q), 32'd4);
        chk("cnt_novalid_hold", 32'(rngValid), 32'd0);
        buttonPush = 1'b1;
        tick();
        chk("cnt_out",   32'(rngOut),   32'd4);
        chk("cnt_valid", 32'(rngValid), 32'd1);
        chk("cnt_nobusy", 32'(busy),    32'd0);

        // Overrun: two presses while pending, no ack
        buttonPush = 1'b0;
        tick(2);
        buttonPush = 1'b1;
        tick();
        chk("ovr_flag",  32'(overrun),     32'd1);
        chk("ovr_out",   32'(rngOut),      32'd4);
        chk("ovr_state", 32'(dut.state_q), 32'd6);
        chk("ovr_valid", 32'(rngValid),    32'd1);

        // Ack while pressed -> HOLD, state keeps advancing
        buttonPush = 1'b0;
        rngAck     = 1'b1;
        tick();
        rngAck = 1'b0;
        chk("ackp_busy",  32'(busy),        32'd1);
        chk("ackp_valid", 32'(rngValid),    32'd0);
        chk("ackp_state", 32'(dut.state_q), 32'd7);
        buttonPush = 1'b1;
        tick();
        chk("ackp_out", 32'(rngOut), 32'd7);

        // Ack while released -> IDLE
        rngAck = 1'b1;
        tick();
        rngAck = 1'b0;
        chk("ack_valid", 32'(rngValid), 32'd0);
        chk("ack_idle",  32'(dut.fsm_q), 32'd0);
        chk("ack_sticky_ovr", 32'(overrun), 32'd1);

        // Wrap: 12 advances from 0 -> 2, never above 9
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrap_rst_ovr", 32'(overrun), 32'd0);
        buttonPush = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("wrap_bound", 32'(dut.state_q <= 4'd9), 32'd1);
        end
        buttonPush = 1'b1;
        tick();
        chk("wrap_out", 32'(rngOut), 32'd2);
        rngAck = 1'b1;
        tick();
        rngAck = 1'b0;

        // LFSR from seed 1: 12, 6, 3
        mode = 1'b1;
        tick();
        chk("lfsr_mode", 32'(dut.mode_q), 32'd1);
        seedLoad = 1'b1;
        seedVal  = 4'd1;
        tick();
        seedLoad = 1'b0;
        chk("lfsr_seed", 32'(dut.state_q), 32'd1);
        buttonPush = 1'b0;
        tick();
        chk("lfsr_s1", 32'(dut.state_q), 32'd12);
        tick();
        chk("lfsr_s2", 32'(dut.state_q), 32'd6);
        tick();
        chk("lfsr_s3", 32'(dut.state_q), 32'd3);
        buttonPush = 1'b1;
        tick();
        chk("lfsr_out", 32'(rngOut), 32'd3);
        rngAck = 1'b1;
        tick();
        rngAck = 1'b0;

        // Zero-lock: zero seed loads SEED; zero state steps to SEED
        seedLoad = 1'b1;
        seedVal  = 4'd0;
        tick();
        seedLoad = 1'b0;
        chk("zl_seed0", 32'(dut.state_q), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        buttonPush = 1'b0;
        tick();
        chk("zl_step", 32'(dut.state_q), 32'd1);
        tick();
        chk("zl_step2", 32'(dut.state_q), 32'd12);
        buttonPush = 1'b1;
        tick();
        chk("zl_out", 32'(rngOut), 32'd12);
        rngAck = 1'b1;
        tick();
        rngAck = 1'b0;

        // Mode toggle in HOLD ignored for that press
        mode = 1'b0;
        tick();
        seedLoad = 1'b1;
        seedVal  = 4'd3;
        tick();
        seedLoad = 1'b0;
        buttonPush = 1'b0;
        tick();
        mode = 1'b1;
        tick(2);
        chk("mt_state", 32'(dut.state_q), 32'd6);
        buttonPush = 1'b1;
        tick();
        chk("mt_out", 32'(rngOut), 32'd6);
        buttonPush = 1'b0;
        tick();
        chk("mt_ovr",   32'(overrun),     32'd1);
        chk("mt_keep",  32'(rngOut),      32'd6);
        buttonPush = 1'b1;
        rngAck     = 1'b1;
        tick();
        rngAck = 1'b0;
        tick();
        chk("mt_mode_idle", 32'(dut.mode_q), 32'd1);
        buttonPush = 1'b0;
        tick();
        chk("mt_lfsr_step", 32'(dut.state_q), 32'd15);
        chk("mt_busy",      32'(busy),        32'd1);

        // Reset mid-HOLD overrides the press
        rst = 1'b1;
        tick();
        rst = 1'b0;
        buttonPush = 1'b1;
        chk("rh_out",     32'(rngOut),      32'd0);
        chk("rh_valid",   32'(rngValid),    32'd0);
        chk("rh_overrun", 32'(overrun),     32'd0);
        chk("rh_busy",    32'(busy),        32'd0);
        chk("rh_state",   32'(dut.state_q), 32'd0);
        chk("rh_mode",    32'(dut.mode_q),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rng_param_gen
